pong_frame_scheduler: RTL and testbench
=======================================

PONG_FRAME_SCHEDULER -- requirements
Module: pong_frame_scheduler

Interface
REQ-001 SHALL have parameter PADDLE_H, default 64, paddle height in pixels.
REQ-002 SHALL have parameter PADDLE_W, default 8, paddle width in pixels.
REQ-003 SHALL have parameter BALL_SZ, default 8, ball side length in pixels.
REQ-004 SHALL have parameter BALL_STEP, default 2, ball pixels moved per frame per axis.
REQ-005 SHALL have parameter PAD_STEP, default 4, paddle pixels moved per frame.
REQ-006 SHALL have parameter SERVE_FRAMES, default 60, frames held in SERVE.
REQ-007 SHALL have port clk  in  1  pixel clock; the only clock.
REQ-008 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-009 SHALL have ports xpix, ypix  in  10 each  current scan position from the VGA timing block.
REQ-010 SHALL have ports p1_up, p1_dn, p2_up, p2_dn  in  1 each  paddle buttons, synchronous to clk.
REQ-011 SHALL have port start  in  1  start/restart request.
REQ-012 SHALL have port pixval  out  1  object-present bit for the current pixel.
REQ-013 SHALL have port altcolor  out  1  high in OVER state.
REQ-014 SHALL have ports score1, score2  out  4 each  player scores, 0..9.
REQ-015 SHALL have port state  out  2  IDLE=0, SERVE=1, PLAY=2, OVER=3.

Function
REQ-016 SHALL generate a registered one-cycle tick when xpix==0 and ypix==480; every game-state, position and score update occurs only on a tick.
REQ-017 SHALL drive pixval registered, one clk after xpix/ypix are presented: 1 when inside ball, left paddle (x 16..16+PADDLE_W-1), right paddle (x 616..616+PADDLE_W-1) or net (x 318..319 with ypix[3]==0); 0 when xpix>=640 or ypix>=480.
REQ-018 SHALL hold paddle y in 0..480-PADDLE_H; per tick, up alone subtracts PAD_STEP, down alone adds PAD_STEP, both or neither holds; results saturate at the limits, never wrap.
REQ-019 IDLE: ball at (316,236), scores 0; start high at a tick -> SERVE, direction right/down.
REQ-020 SERVE: ball held at (316,236), paddles movable, frame counter counts ticks; after SERVE_FRAMES ticks -> PLAY; counter clears on entry.
REQ-021 PLAY: per tick ball x and y each move BALL_STEP in current direction (dx, dy flags).
REQ-022 Wall: ball y<=BALL_STEP moving up, or y>=480-BALL_SZ-BALL_STEP moving down, flips dy and clamps y to that bound.
REQ-023 Paddle hit: moving left with x<=16+PADDLE_W and ball y-span overlapping left paddle flips dx to right; symmetric for the right paddle at x+BALL_SZ>=616; wall and paddle flips in the same tick both apply.
REQ-024 Miss: moving left with x<=BALL_STEP and no hit -> score2+1, SERVE, dx toward player 1; symmetric miss on right (x>=640-BALL_SZ-BALL_STEP) -> score1+1, SERVE, dx toward player 2.
REQ-025 A score reaching 9 -> OVER instead of SERVE; scores never exceed 9.
REQ-026 OVER: ball and scores frozen; start high at a tick -> IDLE; start in SERVE or PLAY ignored.
REQ-027 All position arithmetic SHALL be 10-bit unsigned with no underflow or overflow wrap.

Reset
REQ-028 rst high SHALL immediately force state=IDLE, ball (316,236), dx right, dy down, paddles y=208, scores 0, counter 0, tick 0, pixval 0, altcolor 0, including mid-frame or mid-PLAY.
REQ-029 After rst deasserts, the first update SHALL occur at the next tick.

Verification
REQ-030 Reset then xpix=320,ypix=240 -> pixval=1 one cycle later (ball/net); xpix=700 -> pixval=0.
REQ-031 p1_up held 60 frames from y=208 -> left paddle y=0 after 52 ticks, stays 0; p1_up+p1_dn together -> no movement.
REQ-032 start at a tick -> state=1; after 60 ticks state=2; ball x advances 2 per tick.
REQ-033 PLAY with right paddle aligned to ball -> dx flips at x+8>=616, score unchanged; paddle moved away -> score1 increments, state=1.
REQ-034 Nine consecutive player-1 points -> score1=9, state=3, altcolor=1; start at tick -> state=0, scores 0.
REQ-035 rst asserted mid-PLAY between ticks -> all outputs at reset values same cycle, no tick-dependent delay.

Source files
------------

// File: rtl/pong_frame_scheduler.sv
// Pong game engine driven by a VGA scan position: advances the game once per
// frame (at the first blanked line) and renders a one-bit object mask per pixel.
// Ports:
//   clk, rst           pixel clock, asynchronous active-high reset
//   xpix, ypix         current scan position from the timing generator
//   p1_up .. p2_dn     paddle buttons (synchronous to clk)
//   start              start / restart request, sampled on frame ticks
//   pixval             registered object-present bit for the presented pixel
//   altcolor           high while the game is over
//   score1, score2     player scores 0..9
//   state              IDLE=0, SERVE=1, PLAY=2, OVER=3
module pong_frame_scheduler #(
    parameter int unsigned PADDLE_H     = 64,
    parameter int unsigned PADDLE_W     = 8,
    parameter int unsigned BALL_SZ      = 8,
    parameter int unsigned BALL_STEP    = 2,
    parameter int unsigned PAD_STEP     = 4,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] xpix,
    input  logic [9:0] ypix,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    input  logic       start,
    output logic       pixval,
    output logic       altcolor,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] state
);

    localparam int unsigned CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    localparam logic [9:0] SCR_W     = 10'd640;
    localparam logic [9:0] SCR_H     = 10'd480;
    localparam logic [9:0] BALL_X0   = 10'd316;
    localparam logic [9:0] BALL_Y0   = 10'd236;
    localparam logic [9:0] PAD_Y0    = 10'd208;
    localparam logic [9:0] LPAD_X    = 10'd16;
    localparam logic [9:0] RPAD_X    = 10'd616;
    localparam logic [9:0] NET_X     = 10'd318;
    localparam logic [9:0] PAD_Y_MAX = 10'(480 - PADDLE_H);
    localparam logic [9:0] BALL_Y_MX = 10'(480 - BALL_SZ);
    localparam logic [9:0] BALL_X_MX = 10'(640 - BALL_SZ);
    localparam logic [9:0] WALL_LO   = 10'(BALL_STEP);
    localparam logic [9:0] WALL_HI   = 10'(480 - BALL_SZ - BALL_STEP);
    localparam logic [9:0] MISS_R_X  = 10'(640 - BALL_SZ - BALL_STEP);
    localparam logic [9:0] HIT_L_X   = 10'(16 + PADDLE_W);
    localparam logic [3:0] SCORE_MAX = 4'd9;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t           state_q,    state_d;
    logic             tick_q,     tick_d;
    logic             pixval_q,   pixval_d;
    logic             altcolor_q, altcolor_d;
    logic [9:0]       ball_x_q,   ball_x_d;
    logic [9:0]       ball_y_q,   ball_y_d;
    logic             dx_q,       dx_d;      // 1 = moving right
    logic             dy_q,       dy_d;      // 1 = moving down
    logic [9:0]       pad1_q,     pad1_d;
    logic [9:0]       pad2_q,     pad2_d;
    logic [3:0]       score1_q,   score1_d;
    logic [3:0]       score2_q,   score2_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic       in_ball, in_lpad, in_rpad, in_net, on_screen;
    logic       hit_l, hit_r, miss_l, miss_r;
    logic       dx_new;
    logic [10:0] x_right;

    // Paddle step with saturation at both screen limits.
    function automatic logic [9:0] pad_next(input logic [9:0] y,
                                            input logic up,
                                            input logic dn);
        logic [10:0] sum;
        logic [9:0]  res;
        sum = {1'b0, y} + 11'(PAD_STEP);
        res = y;
        if (up && !dn) begin
            res = (y > 10'(PAD_STEP)) ? (y - 10'(PAD_STEP)) : 10'd0;
        end else if (dn && !up) begin
            res = (sum > {1'b0, PAD_Y_MAX}) ? PAD_Y_MAX : sum[9:0];
        end
        return res;
    endfunction

    // Ball vertical span intersects paddle vertical span.
    function automatic logic spans(input logic [9:0] by, input logic [9:0] py);
        return ({1'b0, by} < ({1'b0, py} + 11'(PADDLE_H))) &&
               (({1'b0, by} + 11'(BALL_SZ)) > {1'b0, py});
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= SCORE_MAX) ? SCORE_MAX : (s + 4'd1);
    endfunction

    // Pixel mask and frame tick from the presented scan position.
    always_comb begin
        tick_d    = (xpix == 10'd0) && (ypix == SCR_H);
        on_screen = (xpix < SCR_W) && (ypix < SCR_H);
        in_ball   = (xpix >= ball_x_q) && ({1'b0, xpix} < ({1'b0, ball_x_q} + 11'(BALL_SZ))) &&
                    (ypix >= ball_y_q) && ({1'b0, ypix} < ({1'b0, ball_y_q} + 11'(BALL_SZ)));
        in_lpad   = (xpix >= LPAD_X) && ({1'b0, xpix} < ({1'b0, LPAD_X} + 11'(PADDLE_W))) &&
                    (ypix >= pad1_q) && ({1'b0, ypix} < ({1'b0, pad1_q} + 11'(PADDLE_H)));
        in_rpad   = (xpix >= RPAD_X) && ({1'b0, xpix} < ({1'b0, RPAD_X} + 11'(PADDLE_W))) &&
                    (ypix >= pad2_q) && ({1'b0, ypix} < ({1'b0, pad2_q} + 11'(PADDLE_H)));
        in_net    = ((xpix == NET_X) || (xpix == (NET_X + 10'd1))) && !ypix[3];
        pixval_d  = on_screen && (in_ball || in_lpad || in_rpad || in_net);
    end

    // Collision and miss detection on the pre-update positions.
    always_comb begin
        hit_l  = !dx_q && (ball_x_q <= HIT_L_X) && spans(ball_y_q, pad1_q);
        hit_r  = dx_q && (({1'b0, ball_x_q} + 11'(BALL_SZ)) >= {1'b0, RPAD_X}) &&
                 spans(ball_y_q, pad2_q);
        miss_l = !dx_q && (ball_x_q <= WALL_LO) && !hit_l;
        miss_r = dx_q && (ball_x_q >= MISS_R_X) && !hit_r;
        dx_new = hit_l ? 1'b1 : (hit_r ? 1'b0 : dx_q);
        x_right = {1'b0, ball_x_q} + 11'(BALL_STEP);
    end

    // Game state machine: next state and datapath, all gated by the frame tick.
    always_comb begin
        state_d  = state_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        pad1_d   = pad1_q;
        pad2_d   = pad2_q;
        score1_d = score1_q;
        score2_d = score2_q;
        cnt_d    = cnt_q;

        if (tick_q) begin
            pad1_d = pad_next(pad1_q, p1_up, p1_dn);
            pad2_d = pad_next(pad2_q, p2_up, p2_dn);
            case (state_q)
                ST_IDLE: begin
                    ball_x_d = BALL_X0;
                    ball_y_d = BALL_Y0;
                    if (start) begin
                        state_d = ST_SERVE;
                        dx_d    = 1'b1;
                        dy_d    = 1'b1;
                        cnt_d   = '0;
                    end
                end
                ST_SERVE: begin
                    ball_x_d = BALL_X0;
                    ball_y_d = BALL_Y0;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (miss_l) begin
                        score2_d = sat_inc(score2_q);
                        if (score2_q >= (SCORE_MAX - 4'd1)) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d  = ST_SERVE;
                            cnt_d    = '0;
                            dx_d     = 1'b0;
                            ball_x_d = BALL_X0;
                            ball_y_d = BALL_Y0;
                        end
                    end else if (miss_r) begin
                        score1_d = sat_inc(score1_q);
                        if (score1_q >= (SCORE_MAX - 4'd1)) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d  = ST_SERVE;
                            cnt_d    = '0;
                            dx_d     = 1'b1;
                            ball_x_d = BALL_X0;
                            ball_y_d = BALL_Y0;
                        end
                    end else begin
                        // Walls clamp to the screen edge; otherwise step vertically.
                        if (!dy_q && (ball_y_q <= WALL_LO)) begin
                            dy_d     = 1'b1;
                            ball_y_d = 10'd0;
                        end else if (dy_q && (ball_y_q >= WALL_HI)) begin
                            dy_d     = 1'b0;
                            ball_y_d = BALL_Y_MX;
                        end else if (dy_q) begin
                            ball_y_d = ball_y_q + 10'(BALL_STEP);
                        end else begin
                            ball_y_d = ball_y_q - 10'(BALL_STEP);
                        end
                        // Paddle bounce takes effect on this tick's horizontal step.
                        dx_d = dx_new;
                        if (dx_new) begin
                            ball_x_d = (x_right > {1'b0, BALL_X_MX}) ? BALL_X_MX : x_right[9:0];
                        end else begin
                            ball_x_d = (ball_x_q > WALL_LO) ? (ball_x_q - 10'(BALL_STEP)) : 10'd0;
                        end
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        state_d  = ST_IDLE;
                        ball_x_d = BALL_X0;
                        ball_y_d = BALL_Y0;
                        dx_d     = 1'b1;
                        dy_d     = 1'b1;
                        score1_d = 4'd0;
                        score2_d = 4'd0;
                        cnt_d    = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        altcolor_d = (state_d == ST_OVER);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tick_q     <= 1'b0;
            pixval_q   <= 1'b0;
            altcolor_q <= 1'b0;
            ball_x_q   <= BALL_X0;
            ball_y_q   <= BALL_Y0;
            dx_q       <= 1'b1;
            dy_q       <= 1'b1;
            pad1_q     <= PAD_Y0;
            pad2_q     <= PAD_Y0;
            score1_q   <= 4'd0;
            score2_q   <= 4'd0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            pixval_q   <= pixval_d;
            altcolor_q <= altcolor_d;
            ball_x_q   <= ball_x_d;
            ball_y_q   <= ball_y_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            pad1_q     <= pad1_d;
            pad2_q     <= pad2_d;
            score1_q   <= score1_d;
            score2_q   <= score2_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pixval   = pixval_q;
    assign altcolor = altcolor_q;
    assign score1   = score1_q;
    assign score2   = score2_q;
    assign state    = state_q;

endmodule

// File: tb/tb_pong_frame_scheduler.sv
// Bench for pong_frame_scheduler: a frame-level game model runs alongside the
// DUT and is compared every cycle; directed literal checks pin the model.
// Frames are compressed: a tick is produced by presenting (0,480) for one cycle.
module tb_pong_frame_scheduler;

    localparam int PH = 64, PW = 8, BS = 8, BSTEP = 2, PSTEP = 4, SERVE_N = 60;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] xpix, ypix;
    logic       p1_up, p1_dn, p2_up, p2_dn, start;
    logic       pixval, altcolor;
    logic [3:0] score1, score2;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    pong_frame_scheduler dut (
        .clk(clk), .rst(rst), .xpix(xpix), .ypix(ypix),
        .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
        .start(start), .pixval(pixval), .altcolor(altcolor),
        .score1(score1), .score2(score2), .state(state)
    );

    always #5 clk = ~clk;

    // ---------------- game model ----------------
    int m_state = 0, m_bx = 316, m_by = 236, m_dx = 1, m_dy = 1;
    int m_p1 = 208, m_p2 = 208, m_s1 = 0, m_s2 = 0, m_cnt = 0;
    int m_pix = 0, m_tick_pend = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int inside_rect(int x, int y, int rx, int ry, int w, int h);
        return (x >= rx && x < rx + w && y >= ry && y < ry + h) ? 1 : 0;
    endfunction

    function automatic int object_at(int x, int y);
        if (x >= 640 || y >= 480) return 0;
        if (inside_rect(x, y, m_bx, m_by, BS, BS) != 0) return 1;
        if (inside_rect(x, y, 16, m_p1, PW, PH) != 0) return 1;
        if (inside_rect(x, y, 616, m_p2, PW, PH) != 0) return 1;
        if ((x == 318 || x == 319) && ((y / 8) % 2 == 0)) return 1;
        return 0;
    endfunction

    function automatic int move_pad(int y, logic up, logic dn);
        int t;
        t = y + (int'(dn) - int'(up)) * PSTEP;
        if (t < 0) t = 0;
        if (t > 480 - PH) t = 480 - PH;
        return t;
    endfunction

    function automatic int overlaps(int by, int py);
        return (by < py + PH && by + BS > py) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
        m_p1 = 208; m_p2 = 208; m_s1 = 0; m_s2 = 0; m_cnt = 0;
        m_pix = 0; m_tick_pend = 0;
    endtask

    task automatic award(input int who);
        int s;
        if (who == 1) begin m_s1++; s = m_s1; end
        else          begin m_s2++; s = m_s2; end
        if (s == 9) m_state = 3;
        else begin
            m_state = 1; m_cnt = 0; m_bx = 316; m_by = 236;
            m_dx = (who == 1) ? 1 : -1;
        end
    endtask

    task automatic model_frame();
        int op1, op2, hl, hr;
        op1 = m_p1; op2 = m_p2;
        m_p1 = move_pad(m_p1, p1_up, p1_dn);
        m_p2 = move_pad(m_p2, p2_up, p2_dn);
        case (m_state)
            0: if (start) begin m_state = 1; m_dx = 1; m_dy = 1; m_cnt = 0; end
            1: begin
                m_cnt++;
                if (m_cnt == SERVE_N) begin m_state = 2; m_cnt = 0; end
            end
            2: begin
                hl = (m_dx < 0 && m_bx <= 16 + PW && overlaps(m_by, op1) != 0) ? 1 : 0;
                hr = (m_dx > 0 && m_bx + BS >= 616 && overlaps(m_by, op2) != 0) ? 1 : 0;
                if (m_dx < 0 && m_bx <= BSTEP && hl == 0) award(2);
                else if (m_dx > 0 && m_bx >= 640 - BS - BSTEP && hr == 0) award(1);
                else begin
                    if (m_dy < 0 && m_by <= BSTEP) begin m_by = 0; m_dy = 1; end
                    else if (m_dy > 0 && m_by >= 480 - BS - BSTEP) begin m_by = 480 - BS; m_dy = -1; end
                    else m_by = m_by + m_dy * BSTEP;
                    if (hl != 0) m_dx = 1;
                    if (hr != 0) m_dx = -1;
                    m_bx = m_bx + m_dx * BSTEP;
                end
            end
            default: if (start) begin
                m_state = 0; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
                m_s1 = 0; m_s2 = 0;
            end
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else begin
            m_pix = object_at(int'(xpix), int'(ypix));
            if (m_tick_pend != 0) model_frame();
            m_tick_pend = (xpix == 10'd0 && ypix == 10'd480) ? 1 : 0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("state",    int'(state),    m_state);
        check("score1",   int'(score1),   m_s1);
        check("score2",   int'(score2),   m_s2);
        check("altcolor", int'(altcolor), (m_state == 3) ? 1 : 0);
        check("pixval",   int'(pixval),   m_pix);
    end

    // ---------------- stimulus ----------------
    task automatic frames(input int n);
        repeat (n) begin
            @(negedge clk); xpix = 10'd0;   ypix = 10'd480;
            @(negedge clk); xpix = 10'd700; ypix = 10'd500;
            @(negedge clk);
        end
    endtask

    task automatic probe(input int x, input int y, input int exp, input string nm);
        @(negedge clk); xpix = 10'(x); ypix = 10'(y);
        @(negedge clk); check(nm, int'(pixval), exp);
    endtask

    initial begin
        rst = 1'b1; xpix = 10'd700; ypix = 10'd500;
        p1_up = 0; p1_dn = 0; p2_up = 0; p2_dn = 0; start = 0;
        repeat (3) @(negedge clk);
        check("rst_state", int'(state), 0);
        check("rst_score1", int'(score1), 0);
        check("rst_pixval", int'(pixval), 0);
        check("rst_altcolor", int'(altcolor), 0);
        rst = 1'b0;

        probe(320, 240, 1, "ball_center");
        probe(700, 240, 0, "offscreen_x");
        probe(318, 0, 1, "net_dash");
        probe(318, 8, 0, "net_gap");
        probe(16, 208, 1, "p1_top");
        probe(16, 207, 0, "p1_above");

        // Left paddle up to the top and saturating there.
        p1_up = 1;
        frames(51);
        probe(16, 4, 1, "p1_y4");
        probe(16, 3, 0, "p1_y4_above");
        frames(1);
        probe(16, 0, 1, "p1_y0");
        frames(8);
        probe(16, 0, 1, "p1_sat_top");
        probe(16, 64, 0, "p1_sat_bottom");
        p1_dn = 1;
        frames(4);
        probe(16, 64, 0, "p1_both_hold");
        p1_up = 0; p1_dn = 0;

        // Rally with right paddle aligned: bounce, no score.
        start = 1; frames(1); start = 0;
        check("serve_entry", int'(state), 1);
        p2_dn = 1; frames(40); p2_dn = 0;
        probe(616, 368, 1, "p2_y368");
        probe(616, 367, 0, "p2_above");
        probe(323, 236, 1, "serve_ball_held");
        frames(19);
        check("serve_59", int'(state), 1);
        frames(1);
        check("play_entry", int'(state), 2);
        frames(1);
        probe(325, 238, 1, "ball_x318");
        probe(326, 238, 0, "ball_x318_edge");
        frames(1);
        probe(327, 241, 1, "ball_x320");
        probe(328, 241, 0, "ball_x320_edge");
        start = 1; frames(2); start = 0;
        check("start_ignored_play", int'(state), 2);
        frames(142);
        probe(608, 416, 1, "ball_at_608");
        probe(607, 416, 0, "ball_at_608_edge");
        frames(1);
        check("bounce_no_score", int'(score1), 0);
        check("bounce_state", int'(state), 2);
        probe(606, 414, 1, "bounce_x606");
        probe(614, 414, 0, "bounce_moved_left");

        // Asynchronous reset between ticks.
        @(negedge clk); xpix = 10'd318; ypix = 10'd0;
        @(posedge clk); #2;
        check("pre_rst_pixval", int'(pixval), 1);
        rst = 1'b1; #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_pixval", int'(pixval), 0);
        check("async_rst_altcolor", int'(altcolor), 0);
        @(negedge clk); rst = 1'b0;

        // Nine straight right-side misses: player 1 wins.
        start = 1; frames(1); start = 0;
        frames(60);
        check("play_after_60", int'(state), 2);
        for (int p = 1; p <= 9; p++) begin
            if (p > 1) begin
                frames(60);
                check("reserve_done", int'(state), 2);
            end
            frames(157);
            check("rally_state", int'(state), 2);
            check("rally_score1", int'(score1), p - 1);
            frames(1);
            check("point_score1", int'(score1), p);
            check("point_state", int'(state), (p < 9) ? 1 : 3);
        end
        check("over_altcolor", int'(altcolor), 1);
        check("over_score2", int'(score2), 0);
        frames(3);
        check("over_frozen", int'(score1), 9);
        probe(630, 394, 1, "over_ball_frozen");
        probe(322, 240, 0, "over_not_center");
        start = 1; frames(1); start = 0;
        check("restart_state", int'(state), 0);
        check("restart_score1", int'(score1), 0);
        check("restart_altcolor", int'(altcolor), 0);
        probe(322, 240, 1, "idle_center");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
